// File: rtl/ro_puf_pkg.sv
// Shared types and constants for the RO-PUF measurement controller.
//   state_e    : controller phase encoding
//   CNT_W      : edge counter width
//   CNT_SAT    : counter value that means the counter saturated
//   tmr_width(): width of the shared phase timer for the given phase lengths
package ro_puf_pkg;

  localparam int unsigned CNT_W = 16;
  localparam logic [CNT_W-1:0] CNT_SAT = '1;

  typedef enum logic [2:0] {
    StIdle,
    StClear,
    StRun,
    StSettle,
    StCapture,
    StDone
  } state_e;

  // The timer is loaded with (length - 1), so $clog2(longest) bits suffice.
  function automatic int unsigned tmr_width(int unsigned win, int unsigned clr,
                                            int unsigned settle);
    int unsigned m;
    m = win;
    if (clr > m) m = clr;
    if (settle > m) m = settle;
    return (m < 2) ? 1 : $clog2(m);
  endfunction

endpackage

// File: rtl/ro_puf_phase_timer.sv
// Down-counting phase timer shared by all controller phases.
//   clk      : system clock
//   Reset    : synchronous active-high reset (clears count)
//   load     : load load_val (takes priority over tick)
//   load_val : phase length minus one
//   tick     : decrement by one; holds at zero
//   expired  : count has reached zero (last cycle of the phase)
module ro_puf_phase_timer #(
  parameter int unsigned Width = 4
) (
  input  logic             clk,
  input  logic             Reset,
  input  logic             load,
  input  logic [Width-1:0] load_val,
  input  logic             tick,
  output logic             expired
);

  logic [Width-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (Reset) begin
      cnt_q <= '0;
    end else if (load) begin
      cnt_q <= load_val;
    end else if (tick && (cnt_q != '0)) begin
      cnt_q <= cnt_q - 1'b1;
    end
  end

  assign expired = (cnt_q == '0);

endmodule

// File: rtl/ro_puf_measure_ctrl.sv
// RO-PUF key generation sequencer. Walks NUM_BITS RO pairs; for each pair clears the
// edge counters, enables the oscillators for a fixed window, waits for late edges to
// land, then compares the two counts into one key bit.
//   clk, Reset     : clock, synchronous active-high reset
//   start          : begin a key (only honoured in idle)
//   cnt_a, cnt_b   : edge counts of the selected pair
//   ro_sel         : selected pair index
//   ro_en, cnt_rst : oscillator enable, counter clear
//   busy, done     : run in progress, one-cycle completion pulse
//   key, key_valid : response vector and its validity flag
//   tie_cnt        : pairs with equal counts in the last run
//   sat_err        : some count saturated in the last run
module ro_puf_measure_ctrl
  import ro_puf_pkg::*;
#(
  parameter int unsigned NUM_BITS      = 128,
  parameter int unsigned SEL_W         = 7,
  parameter int unsigned WINDOW_CYCLES = 1024,
  parameter int unsigned CLR_CYCLES    = 2,
  parameter int unsigned SETTLE_CYCLES = 4
) (
  input  logic                clk,
  input  logic                Reset,
  input  logic                start,
  input  logic [CNT_W-1:0]    cnt_a,
  input  logic [CNT_W-1:0]    cnt_b,
  output logic [SEL_W-1:0]    ro_sel,
  output logic                ro_en,
  output logic                cnt_rst,
  output logic                busy,
  output logic                done,
  output logic [NUM_BITS-1:0] key,
  output logic                key_valid,
  output logic [SEL_W:0]      tie_cnt,
  output logic                sat_err
);

  localparam int unsigned TmrW = tmr_width(WINDOW_CYCLES, CLR_CYCLES, SETTLE_CYCLES);
  localparam logic [TmrW-1:0] ClrLoad    = TmrW'(CLR_CYCLES - 1);
  localparam logic [TmrW-1:0] WinLoad    = TmrW'(WINDOW_CYCLES - 1);
  localparam logic [TmrW-1:0] SettleLoad = TmrW'(SETTLE_CYCLES - 1);
  localparam logic [SEL_W-1:0] LastSel   = SEL_W'(NUM_BITS - 1);

  state_e state_q, state_d;

  logic [SEL_W-1:0]    ro_sel_q;
  logic [NUM_BITS-1:0] key_q;
  logic                key_valid_q;
  logic [SEL_W:0]      tie_cnt_q;
  logic                sat_err_q;

  logic            tmr_load;
  logic [TmrW-1:0] tmr_val;
  logic            tmr_tick;
  logic            tmr_expired;

  logic accept;
  logic last_pair;

  assign accept    = (state_q == StIdle) && start;
  assign last_pair = (ro_sel_q == LastSel);

  ro_puf_phase_timer #(
    .Width(TmrW)
  ) u_timer (
    .clk     (clk),
    .Reset   (Reset),
    .load    (tmr_load),
    .load_val(tmr_val),
    .tick    (tmr_tick),
    .expired (tmr_expired)
  );

  always_comb begin
    state_d  = state_q;
    tmr_load = 1'b0;
    tmr_val  = '0;
    tmr_tick = 1'b0;
    ro_en    = 1'b0;
    cnt_rst  = 1'b0;
    busy     = 1'b0;
    done     = 1'b0;
    unique case (state_q)
      StIdle: begin
        cnt_rst = 1'b1;
        if (start) begin
          state_d  = StClear;
          tmr_load = 1'b1;
          tmr_val  = ClrLoad;
        end
      end
      StClear: begin
        cnt_rst = 1'b1;
        busy    = 1'b1;
        if (tmr_expired) begin
          state_d  = StRun;
          tmr_load = 1'b1;
          tmr_val  = WinLoad;
        end else begin
          tmr_tick = 1'b1;
        end
      end
      StRun: begin
        ro_en = 1'b1;
        busy  = 1'b1;
        if (tmr_expired) begin
          state_d  = StSettle;
          tmr_load = 1'b1;
          tmr_val  = SettleLoad;
        end else begin
          tmr_tick = 1'b1;
        end
      end
      StSettle: begin
        busy = 1'b1;
        if (tmr_expired) begin
          state_d = StCapture;
        end else begin
          tmr_tick = 1'b1;
        end
      end
      StCapture: begin
        busy = 1'b1;
        if (last_pair) begin
          state_d = StDone;
        end else begin
          state_d  = StClear;
          tmr_load = 1'b1;
          tmr_val  = ClrLoad;
        end
      end
      StDone: begin
        cnt_rst = 1'b1;
        done    = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (Reset) begin
      state_q     <= StIdle;
      ro_sel_q    <= '0;
      key_q       <= '0;
      key_valid_q <= 1'b0;
      tie_cnt_q   <= '0;
      sat_err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        ro_sel_q    <= '0;
        key_q       <= '0;
        key_valid_q <= 1'b0;
        tie_cnt_q   <= '0;
        sat_err_q   <= 1'b0;
      end
      if (state_q == StCapture) begin
        // Ties resolve to 0 and are counted; saturation is flagged but the bit is kept.
        key_q[ro_sel_q] <= (cnt_a > cnt_b);
        if (cnt_a == cnt_b) tie_cnt_q <= tie_cnt_q + 1'b1;
        if ((cnt_a == CNT_SAT) || (cnt_b == CNT_SAT)) sat_err_q <= 1'b1;
        if (!last_pair) ro_sel_q <= ro_sel_q + 1'b1;
      end
      if (state_q == StDone) key_valid_q <= 1'b1;
    end
  end

  assign ro_sel    = ro_sel_q;
  assign key       = key_q;
  assign key_valid = key_valid_q;
  assign tie_cnt   = tie_cnt_q;
  assign sat_err   = sat_err_q;

endmodule

// File: tb/tb_ro_puf_measure_ctrl.sv
module tb_ro_puf_measure_ctrl;

  localparam int unsigned NB  = 4;
  localparam int unsigned SW  = 2;
  localparam int unsigned WIN = 8;
  localparam int unsigned CLR = 2;
  localparam int unsigned SET = 4;
  localparam int          DONE_AT = NB * (CLR + WIN + SET + 1) + 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst;
  logic          start;
  logic [15:0]   cnt_a, cnt_b;
  logic [SW-1:0] ro_sel;
  logic          ro_en, cnt_rst, busy, done, key_valid, sat_err;
  logic [NB-1:0] key;
  logic [SW:0]   tie_cnt;

  ro_puf_measure_ctrl #(
    .NUM_BITS     (NB),
    .SEL_W        (SW),
    .WINDOW_CYCLES(WIN),
    .CLR_CYCLES   (CLR),
    .SETTLE_CYCLES(SET)
  ) dut (
    .clk      (clk),
    .Reset    (rst),
    .start    (start),
    .cnt_a    (cnt_a),
    .cnt_b    (cnt_b),
    .ro_sel   (ro_sel),
    .ro_en    (ro_en),
    .cnt_rst  (cnt_rst),
    .busy     (busy),
    .done     (done),
    .key      (key),
    .key_valid(key_valid),
    .tie_cnt  (tie_cnt),
    .sat_err  (sat_err)
  );

  typedef struct packed {
    logic [NB-1:0] key;
    logic [SW:0]   tie;
    logic          sat;
  } exp_t;

  exp_t        sb[$];
  logic [15:0] tgt_a[NB];
  logic [15:0] tgt_b[NB];
  int          checks = 0;
  int          failures = 0;

  // Counter model: cleared by cnt_rst, reaches the pair's final count while enabled.
  always @(posedge clk) begin
    if (cnt_rst === 1'b1) begin
      cnt_a <= '0;
      cnt_b <= '0;
    end else if (ro_en === 1'b1) begin
      cnt_a <= tgt_a[ro_sel];
      cnt_b <= tgt_b[ro_sel];
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_pairs(input logic [15:0] a0, b0, a1, b1, a2, b2, a3, b3);
    tgt_a[0] = a0; tgt_b[0] = b0;
    tgt_a[1] = a1; tgt_b[1] = b1;
    tgt_a[2] = a2; tgt_b[2] = b2;
    tgt_a[3] = a3; tgt_b[3] = b3;
  endtask

  task automatic push_expected();
    exp_t e;
    e = '0;
    for (int i = 0; i < NB; i++) begin
      e.key[i] = (tgt_a[i] > tgt_b[i]);
      if (tgt_a[i] == tgt_b[i]) e.tie = e.tie + 1'b1;
      if (tgt_a[i] == 16'hFFFF || tgt_b[i] == 16'hFFFF) e.sat = 1'b1;
    end
    sb.push_back(e);
  endtask

  // Leaves the caller 1 time unit after the start-accepting edge.
  task automatic do_start();
    @(negedge clk);
    start = 1'b1;
    push_expected();
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic wait_done(input int n0, output int n);
    n = n0;
    while (done !== 1'b1 && n < 400) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic check_done(input string tag, input int n);
    exp_t e;
    chk({tag, "_done_cycle"}, 64'(n), 64'(DONE_AT));
    chk({tag, "_busy_in_done"}, 64'(busy), 64'(0));
    if (sb.size() == 0) begin
      checks++;
      failures++;
      $error("FAIL %s_scoreboard observed=empty expected=entry", tag);
    end else begin
      e = sb.pop_front();
      chk({tag, "_key"}, 64'(key), 64'(e.key));
      chk({tag, "_tie_cnt"}, 64'(tie_cnt), 64'(e.tie));
      chk({tag, "_sat_err"}, 64'(sat_err), 64'(e.sat));
    end
  endtask

  initial begin
    int n;
    logic [15:0] en_obs, rst_obs;
    rst   = 1'b1;
    start = 1'b0;
    set_pairs(16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_ro_en", 64'(ro_en), 64'(0));
    chk("rst_cnt_rst", 64'(cnt_rst), 64'(1));
    chk("rst_busy_done", 64'({busy, done}), 64'(0));
    chk("rst_key", 64'(key), 64'(0));
    chk("rst_flags", 64'({key_valid, sat_err, tie_cnt, ro_sel}), 64'(0));

    // Basic run plus phase-timing trace of pair 0, with start pulsed mid-window.
    set_pairs(16'd100, 16'd90, 16'd80, 16'd95, 16'd70, 16'd70, 16'd200, 16'd10);
    do_start();
    en_obs  = '0;
    rst_obs = '0;
    for (int k = 1; k <= 16; k++) begin
      @(negedge clk);
      en_obs[k-1]  = ro_en;
      rst_obs[k-1] = cnt_rst;
      if (k == 1) chk("t2_busy_first_clear", 64'(busy), 64'(1));
      if (k == 15) chk("t2_sel_in_capture", 64'(ro_sel), 64'(0));
      if (k == 16) chk("t2_sel_after_capture", 64'(ro_sel), 64'(1));
      start = (k == 5);
    end
    start = 1'b0;
    chk("t2_ro_en_trace", 64'(en_obs), 64'(16'h03FC));
    chk("t2_cnt_rst_trace", 64'(rst_obs), 64'(16'h8003));
    wait_done(16, n);
    check_done("t1", n);
    @(negedge clk);
    chk("t1_key_valid", 64'(key_valid), 64'(1));
    chk("t1_done_pulse", 64'(done), 64'(0));

    // Saturated pair: bit still written, flag sticky through idle.
    set_pairs(16'd10, 16'd20, 16'd30, 16'd40, 16'hFFFF, 16'd5, 16'd7, 16'd3);
    do_start();
    wait_done(0, n);
    check_done("t3", n);
    repeat (5) @(negedge clk);
    chk("t3_sat_held", 64'(sat_err), 64'(1));
    chk("t3_key_held", 64'(key), 64'(4'b1100));
    chk("t3_valid_held", 64'(key_valid), 64'(1));

    // Next start clears the result registers.
    set_pairs(16'd5, 16'd6, 16'd9, 16'd8, 16'd50, 16'd50, 16'd1, 16'd0);
    do_start();
    @(negedge clk);
    chk("t3_sat_cleared", 64'(sat_err), 64'(0));
    chk("t3_valid_cleared", 64'(key_valid), 64'(0));
    chk("t3_key_cleared", 64'(key), 64'(0));
    wait_done(1, n);
    check_done("t3b", n);

    // Back-to-back: start held across the DONE edge and the following idle edge.
    set_pairs(16'd300, 16'd299, 16'd1, 16'd1, 16'd2, 16'd9, 16'd40, 16'd4);
    start = 1'b1;
    push_expected();
    @(posedge clk);
    @(negedge clk);
    chk("t5_done_start_ignored", 64'({busy, cnt_rst}), 64'(2'b01));
    chk("t5_valid_after_done", 64'(key_valid), 64'(1));
    @(posedge clk);
    #1 start = 1'b0;
    @(negedge clk);
    chk("t5_accepted", 64'({busy, key_valid}), 64'(2'b10));
    wait_done(1, n);
    check_done("t5", n);

    // Reset during the window of pair 1 aborts with no partial key.
    set_pairs(16'd100, 16'd90, 16'd20, 16'd10, 16'd30, 16'd10, 16'd40, 16'd10);
    do_start();
    repeat (20) @(negedge clk);
    chk("t4_in_run_pair1", 64'({ro_en, ro_sel}), 64'({1'b1, 2'd1}));
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("t4_idle_outputs", 64'({ro_en, cnt_rst, busy, done}), 64'(4'b0100));
    chk("t4_key_dropped", 64'({key_valid, key}), 64'(0));
    if (sb.size() != 0) void'(sb.pop_back());
    set_pairs(16'd1, 16'd2, 16'd20, 16'd10, 16'd30, 16'd30, 16'd40, 16'd10);
    do_start();
    wait_done(0, n);
    check_done("t4_fresh", n);
    @(negedge clk);
    chk("t4_fresh_valid", 64'(key_valid), 64'(1));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
